aes256_inv_key_sched: RTL and testbench

AES256_INV_KEY_SCHED -- requirements
Module: aes256_inv_key_sched

---
 rtl/aes256_inv_key_sched_pkg.sv | 25 ++
 rtl/aes256_inv_key_sched_if.sv | 23 ++
 rtl/aes256_inv_key_sched_sbox.sv | 42 ++++
 rtl/aes256_inv_key_sched.sv | 114 +++++++++++
 tb/tb_aes256_inv_key_sched.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes256_inv_key_sched_pkg.sv
// Shared types and constants for the AES-256 inverse key schedule.
// Holds the FSM encoding, word widths and the round-constant lookup.
package aes256_inv_key_sched_pkg;

    localparam int AES_WORD_W = 32;
    localparam int AES_RK_W   = 128;
    localparam int AES_KEY_W  = 256;

    localparam logic [3:0] RC_INIT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT_HI = 2'd1,
        ST_EMIT_LO = 2'd2
    } fsm_state_e;

    // Only rc 1..7 ever feed a step; any other value yields a zero constant.
    function automatic logic [7:0] rcon_byte(input logic [3:0] rc);
        if (rc >= 4'd1 && rc <= 4'd7) begin
            return 8'h01 << (rc - 4'd1);
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes256_inv_key_sched_if.sv
// Load/round-key stream bundle between the key consumer and the inverse schedule.
interface aes256_inv_key_sched_if import aes256_inv_key_sched_pkg::*; ();

    logic                 start;
    logic [AES_KEY_W-1:0] key_in;
    logic [AES_RK_W-1:0]  rk_out;
    logic [3:0]           rk_idx;
    logic                 rk_valid;
    logic                 rk_ready;
    logic                 rk_last;
    logic                 busy;

    modport master (
        output start, key_in, rk_ready,
        input  rk_out, rk_idx, rk_valid, rk_last, busy
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_out, rk_idx, rk_valid, rk_last, busy
    );

endinterface

// File: rtl/aes256_inv_key_sched_sbox.sv
// AES forward S-box: GF(2^8) inverse (a^254) followed by the affine transform.
module aes256_inv_key_sched_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // acc collects a^2 * a^4 * ... * a^128 = a^254, which maps 0 to 0 as required
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = a;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3)
                    ^ rotl8(w_inv, 4) ^ 8'h63;

endmodule

// File: rtl/aes256_inv_key_sched.sv
// Emits AES-256 round keys 14..0 by walking the key schedule backwards from rk13/rk14.
// state   | meaning
// IDLE    | waiting for start
// EMIT_HI | offering win[127:0] as round 2*rc
// EMIT_LO | offering win[255:128] as round 2*rc-1; step window on transfer
module aes256_inv_key_sched import aes256_inv_key_sched_pkg::*; (
    input  logic                  i_clk,
    input  logic                  i_rst,
    aes256_inv_key_sched_if.slave kif
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_EMIT_HI = ST_EMIT_HI;
    localparam logic [1:0] S_EMIT_LO = ST_EMIT_LO;

    logic [1:0]            r_state;
    logic [AES_KEY_W-1:0]  r_win;
    logic [3:0]            r_rc;

    logic [AES_WORD_W-1:0] w_wd [8];
    logic [AES_WORD_W-1:0] w_rot;
    logic [AES_WORD_W-1:0] w_sub_rot;
    logic [AES_WORD_W-1:0] w_prev;
    logic [AES_WORD_W-1:0] w_sub_prev;
    logic [AES_WORD_W-1:0] w_mid;
    logic [AES_WORD_W-1:0] w_first;
    logic [AES_KEY_W-1:0]  w_step;

    // w_wd[k] is w[j+k] of the current window
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_wd[k] = r_win[255 - 32*k -: 32];
        end
    end

    assign w_rot  = {w_wd[3][23:0], w_wd[3][31:24]};
    assign w_prev = w_wd[7] ^ w_wd[6];

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes256_inv_key_sched_sbox u_sbox_rot (
            .i_byte (w_rot[8*b +: 8]),
            .o_byte (w_sub_rot[8*b +: 8])
        );
        aes256_inv_key_sched_sbox u_sbox_prev (
            .i_byte (w_prev[8*b +: 8]),
            .o_byte (w_sub_prev[8*b +: 8])
        );
    end

    assign w_mid   = w_wd[4] ^ w_sub_rot ^ {rcon_byte(r_rc), 24'h0};
    assign w_first = w_wd[0] ^ w_sub_prev;

    // new window, oldest word first: w[j-8] .. w[j-1]
    assign w_step = {w_first,
                     w_wd[1] ^ w_wd[0],
                     w_wd[2] ^ w_wd[1],
                     w_wd[3] ^ w_wd[2],
                     w_mid,
                     w_wd[5] ^ w_wd[4],
                     w_wd[6] ^ w_wd[5],
                     w_prev};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_rc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (kif.start) begin
                        r_win   <= kif.key_in;
                        r_rc    <= RC_INIT;
                        r_state <= S_EMIT_HI;
                    end
                end
                S_EMIT_HI: begin
                    if (kif.rk_ready) begin
                        r_state <= (r_rc == 4'd0) ? S_IDLE : S_EMIT_LO;
                    end
                end
                S_EMIT_LO: begin
                    if (kif.rk_ready) begin
                        r_win   <= w_step;
                        r_rc    <= r_rc - 4'd1;
                        r_state <= S_EMIT_HI;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        kif.rk_out = '0;
        kif.rk_idx = '0;
        case (r_state)
            S_EMIT_HI: begin
                kif.rk_out = r_win[127:0];
                kif.rk_idx = {r_rc[2:0], 1'b0};
            end
            S_EMIT_LO: begin
                kif.rk_out = r_win[255:128];
                kif.rk_idx = {r_rc[2:0], 1'b0} - 4'd1;
            end
            default: ;
        endcase
    end

    assign kif.rk_valid = (r_state != S_IDLE);
    assign kif.busy     = (r_state != S_IDLE);
    assign kif.rk_last  = (r_state == S_EMIT_HI) && (r_rc == 4'd0);

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Scoreboard bench: a forward AES-256 expansion predicts the 15 round keys of each load.
module tb_aes256_inv_key_sched;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes256_inv_key_sched_if kif ();

    aes256_inv_key_sched dut (
        .i_clk (clk),
        .i_rst (rst),
        .kif   (kif)
    );

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } exp_t;

    exp_t         sb [$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   ref_sbox [256];
    logic [127:0] mdl_rk   [15];
    logic [127:0] got_rk   [15];

    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            ref_sbox[p] = x ^ 8'h63;
        end
        ref_sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
    endfunction

    task automatic compute_model(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcb;
        rcb = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t   = sub_word({t[23:0], t[31:24]}) ^ {rcb, 24'h0};
                rcb = {rcb[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // call right after a negedge; the DUT samples start at the following posedge
    task automatic issue_start(input logic [255:0] key);
        compute_model(key);
        kif.key_in = {mdl_rk[13], mdl_rk[14]};
        kif.start  = 1'b1;
        for (int r = 14; r >= 0; r--) sb.push_back('{idx: 4'(r), rk: mdl_rk[r]});
    endtask

    task automatic drain(input int ready_pct, input bit noise, input int stop_idx, output int cycles);
        bit           stalled;
        bit           done;
        logic [127:0] s_out;
        logic [3:0]   s_idx;
        exp_t         e;
        stalled = 1'b0;
        done    = 1'b0;
        cycles  = 0;
        while (!done && sb.size() > 0 && cycles < 500) begin
            @(negedge clk);
            cycles++;
            n_checks++;
            if (kif.rk_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL valid_gap: rk_valid=%b required 1 (pending idx %0d)", kif.rk_valid, sb[0].idx);
            end
            if (stalled) begin
                n_checks++;
                if (kif.rk_out !== s_out || kif.rk_idx !== s_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold: idx=%0d out=%h required idx=%0d out=%h",
                             kif.rk_idx, kif.rk_out, s_idx, s_out);
                end
            end
            kif.rk_ready = (int'($urandom_range(99)) < ready_pct);
            if (noise && sb[0].idx >= 4'd5) begin
                kif.start  = 1'($urandom_range(1));
                kif.key_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                kif.start = 1'b0;
            end
            if (kif.rk_valid === 1'b1 && kif.rk_ready === 1'b1) begin
                e = sb.pop_front();
                n_checks++;
                if (kif.rk_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL rk_idx: got %0d required %0d", kif.rk_idx, e.idx);
                end
                n_checks++;
                if (kif.rk_out !== e.rk) begin
                    n_fail++;
                    $display("FAIL rk_out[%0d]: got %h required %h", e.idx, kif.rk_out, e.rk);
                end
                n_checks++;
                if (kif.rk_last !== (e.idx == 4'd0)) begin
                    n_fail++;
                    $display("FAIL rk_last[%0d]: got %b required %b", e.idx, kif.rk_last, (e.idx == 4'd0));
                end
                got_rk[e.idx] = kif.rk_out;
                if (int'(e.idx) == stop_idx) done = 1'b1;
            end
            stalled = (kif.rk_valid === 1'b1) && !kif.rk_ready;
            s_out   = kif.rk_out;
            s_idx   = kif.rk_idx;
        end
        kif.start = 1'b0;
        if (!done && sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d keys outstanding after %0d cycles, required 0", sb.size(), cycles);
        end
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (kif.busy !== 1'b0 || kif.rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b rk_valid=%b required 0/0", tag, kif.busy, kif.rk_valid);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        kif.start    = 1'b1;
        kif.key_in   = {8{32'hdeadbeef}};
        kif.rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (kif.rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", kif.rk_valid); end
        n_checks++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", kif.busy); end
        n_checks++;
        if (kif.rk_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b required 0", kif.rk_last); end
        n_checks++;
        if (kif.rk_out !== 128'h0) begin n_fail++; $display("FAIL reset_out: got %h required 0", kif.rk_out); end
        n_checks++;
        if (kif.rk_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d required 0", kif.rk_idx); end
        rst       = 1'b0;
        kif.start = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");
    endtask

    task automatic test_fips();
        int cyc;
        @(negedge clk);
        issue_start(C3_KEY);
        drain(100, 1'b0, -1, cyc);
        n_checks++;
        if (cyc != 15) begin n_fail++; $display("FAIL fips_cycles: took %0d cycles required 15", cyc); end
        n_checks++;
        if (got_rk[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            n_fail++; $display("FAIL fips_rk14: got %h required 24fc79ccbf0979e9371ac23c6d68de36", got_rk[14]);
        end
        n_checks++;
        if (got_rk[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin
            n_fail++; $display("FAIL fips_rk1: got %h required 101112131415161718191a1b1c1d1e1f", got_rk[1]);
        end
        n_checks++;
        if (got_rk[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_fail++; $display("FAIL fips_rk0: got %h required 000102030405060708090a0b0c0d0e0f", got_rk[0]);
        end
        @(negedge clk);
        check_idle("fips_busy_drop");
    endtask

    task automatic test_stall();
        int cyc;
        @(negedge clk);
        issue_start(C3_KEY);
        drain(45, 1'b0, -1, cyc);
        n_checks++;
        if (got_rk[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_fail++; $display("FAIL stall_rk0: got %h required 000102030405060708090a0b0c0d0e0f", got_rk[0]);
        end
        @(negedge clk);
        check_idle("stall_busy_drop");
    endtask

    task automatic test_start_ignored();
        int cyc;
        @(negedge clk);
        issue_start(C3_KEY);
        drain(80, 1'b1, -1, cyc);
        @(negedge clk);
        check_idle("start_ignored_end");
    endtask

    task automatic test_reset_mid();
        int           cyc;
        logic [255:0] k;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        issue_start(k);
        drain(100, 1'b0, 10, cyc);
        @(negedge clk);
        rst       = 1'b1;
        kif.start = 1'b1;
        @(negedge clk);
        check_idle("mid_reset_abort");
        n_checks++;
        if (kif.rk_out !== 128'h0) begin n_fail++; $display("FAIL mid_reset_out: got %h required 0", kif.rk_out); end
        rst = 1'b0;
        sb.delete();
        k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        issue_start(k);
        drain(100, 1'b0, -1, cyc);
        @(negedge clk);
        check_idle("mid_reset_restart_end");
    endtask

    task automatic test_back_to_back();
        int           cyc;
        logic [255:0] k;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        issue_start(k);
        drain(100, 1'b0, -1, cyc);
        @(negedge clk);
        check_idle("b2b_gap");
        issue_start(C3_KEY);
        drain(70, 1'b0, -1, cyc);
        n_checks++;
        if (got_rk[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            n_fail++; $display("FAIL b2b_rk14: got %h required 24fc79ccbf0979e9371ac23c6d68de36", got_rk[14]);
        end
        @(negedge clk);
        check_idle("b2b_end");
    endtask

    task automatic test_round_trip();
        int           cyc;
        logic [255:0] k;
        for (int n = 0; n < 3; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            issue_start(k);
            drain(60, 1'b0, -1, cyc);
            n_checks++;
            if ({got_rk[0], got_rk[1]} !== k) begin
                n_fail++;
                $display("FAIL round_trip[%0d]: got %h required %h", n, {got_rk[0], got_rk[1]}, k);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        rst          = 1'b1;
        kif.start    = 1'b0;
        kif.key_in   = '0;
        kif.rk_ready = 1'b0;
        test_reset();
        test_fips();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
